// File: rtl/sid_voice_dca.sv
// SID voice DCA: optional 6581 R-2R DAC shaping of wave/envelope, DC offsets,
// and a one-cycle registered stage feeding a combinational multiply-add.

module sid_voice_dac #(
  parameter int  N  = 12,
  parameter real R2 = 2.20
) (
  input  logic [N-1:0] i_v,
  output logic [N-1:0] o_dac
);

  localparam int ACC_W = N + 18;

  // Unnormalised ladder output for bit k (R=1, 2R=R2, no termination).
  function automatic real dac_raw(input int k);
    real  rn, vn, cur;
    logic rn_inf;
    vn     = 1.0;
    rn     = 0.0;
    rn_inf = 1'b1;
    for (int b = 0; b < k; b++) begin
      if (rn_inf) begin
        rn     = 1.0 + R2;
        rn_inf = 1'b0;
      end else begin
        rn = 1.0 + R2 * rn / (R2 + rn);
      end
    end
    if (rn_inf) begin
      rn = R2;
    end else begin
      rn = R2 * rn / (R2 + rn);
      vn = vn * rn / R2;
    end
    for (int b = k + 1; b < N; b++) begin
      rn  = rn + 1.0;
      cur = vn / rn;
      rn  = R2 * rn / (R2 + rn);
      vn  = rn * cur;
    end
    return vn;
  endfunction

  // Weight normalised so all weights sum to 2^N, in Q.16 fixed point.
  function automatic logic [31:0] dac_wfix(input int k);
    real sum;
    sum = 0.0;
    for (int b = 0; b < N; b++) sum = sum + dac_raw(b);
    return 32'($rtoi(dac_raw(k) * real'(1 << N) * 65536.0 / sum + 0.5));
  endfunction

  function automatic logic [N-1:0] sat_dac(input logic [ACC_W-1:0] v);
    if (v > ACC_W'((1 << N) - 1)) return '1;
    else                          return v[N-1:0];
  endfunction

  logic [ACC_W-1:0] w_term [N];
  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_int;

  for (genvar g = 0; g < N; g++) begin : g_w
    localparam logic [ACC_W-1:0] WGT = ACC_W'(dac_wfix(g));
    assign w_term[g] = i_v[g] ? WGT : '0;
  end

  // Start from 0.5 so truncation below rounds to nearest.
  always_comb begin
    w_acc = ACC_W'(32768);
    for (int k = 0; k < N; k++) w_acc = w_acc + w_term[k];
  end

  assign w_int = w_acc >> 16;
  assign o_dac = sat_dac(w_int);

endmodule

module sid_voice_dca #(
  parameter logic signed [15:0] WAVEFORM_DC_6581 = -16'sh380,
  parameter logic signed [15:0] WAVEFORM_DC_8580 = -16'sh800,
  parameter logic signed [31:0] VOICE_DC_6581    = 32'sh7F800,
  parameter logic signed [31:0] VOICE_DC_8580    = 32'sh0,
  parameter real                DAC_2R_DIV_R     = 2.20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               model,
  input  logic [11:0]        wave,
  input  logic [7:0]         envelope,
  output logic signed [21:0] voice_o
);

  logic [11:0]        w_dac12;
  logic [7:0]         w_dac8;
  logic [11:0]        w_wave_sel;
  logic signed [15:0] w_wave_s;

  sid_voice_dac #(.N(12), .R2(DAC_2R_DIV_R)) u_dac12 (.i_v(wave),     .o_dac(w_dac12));
  sid_voice_dac #(.N(8),  .R2(DAC_2R_DIV_R)) u_dac8  (.i_v(envelope), .o_dac(w_dac8));

  assign w_wave_sel = model ? wave : w_dac12;
  assign w_wave_s   = signed'({4'b0000, w_wave_sel});

  // Stage 1: every model-dependent choice comes from the same sampled model bit.
  logic               r_model_p1;
  logic signed [15:0] r_wave_p1;
  logic [7:0]         r_env_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_model_p1 <= 1'b0;
      r_wave_p1  <= '0;
      r_env_p1   <= '0;
    end else if (active) begin
      r_model_p1 <= model;
      r_wave_p1  <= w_wave_s + (model ? WAVEFORM_DC_8580 : WAVEFORM_DC_6581);
      r_env_p1   <= model ? envelope : w_dac8;
    end
  end

  // Stage 2: multiply-add; the result range always fits 22 bits, so it is
  // computed directly modulo 2^22.
  logic signed [21:0] w_wave_x;
  logic signed [21:0] w_env_x;
  logic signed [21:0] w_dc;

  assign w_wave_x = {{6{r_wave_p1[15]}}, r_wave_p1};
  assign w_env_x  = {14'b0, r_env_p1};
  assign w_dc     = r_model_p1 ? VOICE_DC_8580[21:0] : VOICE_DC_6581[21:0];
  assign voice_o  = w_dc + w_wave_x * w_env_x;

endmodule

// File: tb/tb_sid_voice_dca.sv
// Directed bench for sid_voice_dca: vector table, DAC sweeps via the datapath,
// and a randomised 8580 sequence against a small reference model.

module tb_sid_voice_dca;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               active = 1'b0;
  logic               model = 1'b0;
  logic [11:0]        wave = '0;
  logic [7:0]         envelope = '0;
  logic signed [21:0] voice_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sid_voice_dca dut (
    .clk(clk), .rst(rst), .active(active), .model(model),
    .wave(wave), .envelope(envelope), .voice_o(voice_o)
  );

  typedef struct {
    logic       rst;
    logic       act;
    logic       model;
    logic [11:0] wave;
    logic [7:0] env;
    int         exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic a, input logic m,
                       input logic [11:0] w, input logic [7:0] e);
    @(negedge clk);
    rst = r; active = a; model = m; wave = w; envelope = e;
    @(posedge clk);
    #1;
  endtask

  // Floating-point ladder model, straight from the weight algorithm.
  function automatic int gold_dac(input int n, input int v);
    real  w[12];
    real  rn, vn, cur, sum, acc;
    real  r2;
    logic inf;
    int   res;
    r2  = 2.20;
    sum = 0.0;
    for (int k = 0; k < n; k++) begin
      vn = 1.0; rn = 0.0; inf = 1'b1;
      for (int b = 0; b < k; b++) begin
        if (inf) begin rn = 1.0 + r2; inf = 1'b0; end
        else rn = 1.0 + r2 * rn / (r2 + rn);
      end
      if (inf) rn = r2;
      else begin rn = r2 * rn / (r2 + rn); vn = vn * rn / r2; end
      for (int b = k + 1; b < n; b++) begin
        rn = rn + 1.0; cur = vn / rn; rn = r2 * rn / (r2 + rn); vn = rn * cur;
      end
      w[k] = vn;
      sum  = sum + vn;
    end
    acc = 0.0;
    for (int k = 0; k < n; k++)
      if (((v >> k) & 1) != 0) acc = acc + w[k] * real'(1 << n) / sum;
    res = $rtoi($floor(acc + 0.5));
    if (res > (1 << n) - 1) res = (1 << n) - 1;
    return res;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  int v, d, g, prev, errs, ref_v;
  logic r_r, r_a, r_m;
  logic [11:0] r_w;
  logic [7:0]  r_e;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 522240};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 12'hFFF, 8'hFF, 522240};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 12'hFFF, 8'hFF, 521985};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 12'h000, 8'hFF, -522240};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 12'h800, 8'h37, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 12'h800, 8'hFF, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 12'hFFF, 8'h00, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 12'h000, 8'h01, -2048};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'hFFF, 8'hFF, -2048};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 12'hFFF, 8'hFF, 1337985};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 12'h000, 8'h00, 522240};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h000, 8'hFF, 293760};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 12'hFFF, 8'hFF, 522240};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 12'h123, 8'h45, -121233};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 12'h000, 8'h00, -121233};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 8'hFF, 522240};

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].rst, vecs[i].act, vecs[i].model, vecs[i].wave, vecs[i].env);
      v = voice_o;
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // Wave DAC sweep: with env=0xFF the 8-bit DAC is exactly 255.
    errs = 0;
    prev = -1;
    for (int w = 0; w < 4096; w++) begin
      apply(1'b0, 1'b1, 1'b0, 12'(w), 8'hFF);
      v = voice_o;
      d = (v - 522240) / 255 + 896;
      g = gold_dac(12, w);
      check($sformatf("dac12_exact_w%0d", w), (v - 522240) % 255, 0);
      if (iabs(d - g) > 1) errs++;
      checks++;
      if (iabs(d - g) > 1) begin
        failures++;
        $display("FAIL dac12_w%0d: got %0d expected %0d +-1", w, d, g);
      end
      if (w == 0)    check("dac12_zero", d, 0);
      if (w == 4095) check("dac12_full", d, 4095);
      if (w != 0 && (w & (w - 1)) == 0) begin
        checks++;
        if (d <= prev) begin
          failures++;
          $display("FAIL dac12_mono_w%0d: got %0d required above %0d", w, d, prev);
        end
        prev = d;
      end
    end

    // Envelope DAC sweep: with wave=0 the voice is 522240 - 896*dac8(env).
    prev = -1;
    for (int e = 0; e < 256; e++) begin
      apply(1'b0, 1'b1, 1'b0, 12'h000, 8'(e));
      v = voice_o;
      d = (522240 - v) / 896;
      g = gold_dac(8, e);
      check($sformatf("dac8_exact_e%0d", e), (522240 - v) % 896, 0);
      checks++;
      if (iabs(d - g) > 1) begin
        failures++;
        $display("FAIL dac8_e%0d: got %0d expected %0d +-1", e, d, g);
      end
      if (e == 0)   check("dac8_zero", d, 0);
      if (e == 255) check("dac8_full", d, 255);
      if (e != 0 && (e & (e - 1)) == 0) begin
        checks++;
        if (d <= prev) begin
          failures++;
          $display("FAIL dac8_mono_e%0d: got %0d required above %0d", e, d, prev);
        end
        prev = d;
      end
    end

    // Randomised 8580 sequence with random active/rst against a reference.
    apply(1'b1, 1'b0, 1'b1, 12'h000, 8'h00);
    ref_v = 522240;
    for (int i = 0; i < 400; i++) begin
      r_r = ($urandom_range(0, 15) == 0);
      r_a = ($urandom_range(0, 3) != 0);
      r_m = 1'b1;
      r_w = 12'($urandom_range(0, 4095));
      r_e = 8'($urandom_range(0, 255));
      apply(r_r, r_a, r_m, r_w, r_e);
      if (r_r)      ref_v = 522240;
      else if (r_a) ref_v = (int'(r_w) - 2048) * int'(r_e);
      v = voice_o;
      check($sformatf("rand%0d", i), v, ref_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sid_voice_dca.md
Name:
sid_voice_dca

Overview:
- Voice digitally controlled amplifier (DCA) for one SID voice.
- Takes a 12-bit waveform sample and an 8-bit envelope value.
- For the MOS6581 model, both values first pass through non-linear R-2R ladder DAC models. The block then adds the model-specific DC offsets and computes voice = voice_DC + wave*env.
- Sits between the waveform generator/envelope generator and the filter/mixer. The active input gates the pipeline so the block can be time-shared across voices.

Parameters:
- WAVEFORM_DC_6581, -16'sh380, wave offset for the 6581.
- WAVEFORM_DC_8580, -16'sh800, wave offset for the 8580 (centres the waveform).
- VOICE_DC_6581, 32'sh7F800 (0x800*0xFF), voice DC for the 6581.
- VOICE_DC_8580, 32'sh0, voice DC for the 8580.
- DAC_2R_DIV_R, 2.20 (real, elaboration only), ladder resistor ratio for the 6581 DAC model.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset: synchronous, active-high.
- active, input, 1, pipeline enable. Registers update only when active=1.
- model, input, 1, 0 = MOS6581, 1 = MOS8580.
- wave, input, 12, unsigned waveform sample.
- envelope, input, 8, unsigned envelope value.
- voice_o, output, 22 signed, DCA result.

Behaviour:
- 6581 DAC model dacN(v), instantiated for N=12 and N=8. Weights are computed at elaboration with R=1, 2R=DAC_2R_DIV_R and no termination resistor.
- Weight computation, for each set_bit k:
  - Set Vn=1, Rn=inf.
  - For each lower bit: if Rn=inf then Rn=R+2R, else Rn=R+2R*Rn/(2R+Rn).
  - Then: if Rn=inf then Rn=2R, else {Rn=2R*Rn/(2R+Rn); Vn=Vn*Rn/2R}.
  - For each higher bit: Rn+=R; I=Vn/Rn; Rn=2R*Rn/(2R+Rn); Vn=Rn*I.
  - w[k]=Vn.
- Normalise the weights so that sum(w) = 2^N.
- dacN(v) = floor(sum of w[k] over set bits + 0.5), saturated to 2^N-1.
- Implement dacN as a constant per-bit weight table, at least 16 fractional bits, plus an adder tree. It is combinational, with no state.
- Stage 1, on a clk edge with active=1 and rst=0:
  - model_r <= model.
  - wave_r <= signed16( model==6581 ? dac12(wave) : wave ) + (model==6581 ? WAVEFORM_DC_6581 : WAVEFORM_DC_8580).
  - env_r <= model==6581 ? dac8(envelope) : envelope. This is zero-extended, i.e. non-negative.
- Stage 2 (combinational muladd):
  - res32 = (model_r==6581 ? VOICE_DC_6581 : VOICE_DC_8580) + wave_r*env_r.
  - Signed 32-bit arithmetic.
  - voice_o = res32[21:0].
- Latency: voice_o reflects the inputs sampled at the most recent active clock edge, i.e. one active cycle of latency.
- Range, guaranteed to fit in 22 bits without overflow:
  - 6581: 293760..1337985.
  - 8580: -522240..521985.
- active=0: all registers hold and voice_o is stable.
- Reset:
  - rst=1 clears model_r to 6581, wave_r to 0 and env_r to 0, so voice_o = 0x7F800 (522240).
  - rst has priority over active.
  - Mid-operation reset discards the in-flight sample.
- A model change takes effect coherently: the DC term, the offset and the DAC choice all come from the same sampled model.

Test Plan:
- Reset: assert rst for 1 clk, with active either 0 or 1 -> voice_o=522240 on the next cycle.
- 8580, wave=0xFFF, env=0xFF, active=1 -> voice_o=521985. Then wave=0x000 -> -522240. Then wave=0x800 with any env -> 0.
- 6581, wave=0x000 -> voice_o = 522240 - 896*dac8(env). With env=0 -> 522240. With wave=0xFFF, env=0xFF -> 1337985, since both DACs saturate at full scale.
- DAC unit tests against a floating-point golden model of the weight algorithm, exhaustive over 0..4095 and 0..255:
  - dacN(0)=0 and all-ones gives 2^N-1.
  - Single-bit outputs strictly increase with bit index.
  - Error is at most 1 LSB versus the golden model.
- Gating: change inputs while active=0 -> voice_o unchanged. Assert active for 1 clk -> voice_o updates to the new value.
- Randomised: 10k random (model, wave, envelope, active, rst) sequences -> voice_o bit-exact vs a reference model, with no 22-bit overflow.
